// File: rtl/dcache_pkg.sv
// Shared types and helpers for the data-cache miss sequencer.
// Pure definitions: no latency, no flow control.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    FILL_REQ,
    FILL_WAIT,
    ALLOC
  } t_dcache_state;

  // log2 of the 64-byte block size
  localparam int BLOCK_OFFSET_WIDTH = 6;

  function automatic logic [63:0] block_align(input logic [63:0] addr);
    return {addr[63:BLOCK_OFFSET_WIDTH], {BLOCK_OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_perf_cnt.sv
// Free-running event counter, wraps modulo 2^WIDTH.
// Counts on the clock after i_en; no backpressure.
module dcache_perf_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_en) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/dcache_ctrl.sv
// Miss sequencer: stalls on miss, writes back a dirty victim, fills, allocates.
// Clean miss >= 4 stall cycles; requests held until i_mem_req_ready.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_mem_access,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic                   i_hit,
  input  logic                   i_dirty,
  input  logic [ADDR_WIDTH-1:0]  i_addr_wb,
  input  logic [BLOCK_WIDTH-1:0] i_data_block_wb,
  output logic                   o_stall,
  output logic                   o_block_we,
  output logic [BLOCK_WIDTH-1:0] o_fill_block,
  output logic                   o_mem_req_valid,
  input  logic                   i_mem_req_ready,
  output logic                   o_mem_we,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  output logic [BLOCK_WIDTH-1:0] o_mem_wdata,
  input  logic                   i_mem_resp_valid,
  input  logic [BLOCK_WIDTH-1:0] i_mem_rdata,
  output logic [CNT_WIDTH-1:0]   o_hit_count,
  output logic [CNT_WIDTH-1:0]   o_miss_count,
  output logic [CNT_WIDTH-1:0]   o_wb_count
);

  t_dcache_state          state_q, state_d;
  logic [ADDR_WIDTH-1:0]  miss_addr_q, miss_addr_d;
  logic [BLOCK_WIDTH-1:0] fill_buf_q, fill_buf_d;
  logic [ADDR_WIDTH-1:0]  fill_addr;
  logic                   idle_hit, idle_miss, wb_start;

  assign idle_hit  = (state_q == IDLE) && i_mem_access && i_hit;
  assign idle_miss = (state_q == IDLE) && i_mem_access && !i_hit;
  assign wb_start  = idle_miss && i_dirty;
  assign fill_addr = ADDR_WIDTH'(block_align(64'(miss_addr_q)));

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fill_buf_d  = fill_buf_q;
    case (state_q)
      IDLE: begin
        if (idle_miss) begin
          miss_addr_d = i_addr;
          state_d     = i_dirty ? WB_REQ : FILL_REQ;
        end
      end
      WB_REQ:    if (i_mem_req_ready)  state_d = WB_WAIT;
      WB_WAIT:   if (i_mem_resp_valid) state_d = FILL_REQ;
      FILL_REQ:  if (i_mem_req_ready)  state_d = FILL_WAIT;
      FILL_WAIT: begin
        if (i_mem_resp_valid) begin
          fill_buf_d = i_mem_rdata;
          state_d    = ALLOC;
        end
      end
      ALLOC:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      fill_buf_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      fill_buf_q  <= fill_buf_d;
    end
  end

  // Outputs decode straight from state; victim inputs are stable while stalled.
  always_comb begin
    o_stall         = 1'b1;
    o_block_we      = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_we        = 1'b0;
    o_mem_addr      = '0;
    o_mem_wdata     = '0;
    case (state_q)
      IDLE:     o_stall = i_arst_n && i_mem_access && !i_hit;
      WB_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_we        = 1'b1;
        o_mem_addr      = i_addr_wb;
        o_mem_wdata     = i_data_block_wb;
      end
      FILL_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_addr      = fill_addr;
      end
      ALLOC:    o_block_we = 1'b1;
      default:  ;
    endcase
  end

  assign o_fill_block = fill_buf_q;

  dcache_perf_cnt #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_en(idle_hit), .o_cnt(o_hit_count)
  );

  dcache_perf_cnt #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_en(idle_miss), .o_cnt(o_miss_count)
  );

  dcache_perf_cnt #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_en(wb_start), .o_cnt(o_wb_count)
  );

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized scoreboard bench for dcache_ctrl with a memory responder and a
// second 4-bit-counter instance for wrap checking.
module tb_dcache_ctrl;

  localparam int AW = 64;
  localparam int BW = 512;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          mem_access, hit, dirty;
  logic [AW-1:0] addr, addr_wb;
  logic [BW-1:0] wb_data;
  logic          stall, block_we;
  logic [BW-1:0] fill_block;
  logic          req_valid, req_ready, mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata;
  logic          resp_valid;
  logic [BW-1:0] rdata;
  logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;

  logic          stall4, block_we4, req_valid4, mem_we4;
  logic [BW-1:0] fill_block4, mem_wdata4;
  logic [AW-1:0] mem_addr4;
  logic [3:0]    hit_cnt4, miss_cnt4, wb_cnt4;

  always #5 clk = ~clk;

  dcache_ctrl #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_mem_access(mem_access), .i_addr(addr),
    .i_hit(hit), .i_dirty(dirty), .i_addr_wb(addr_wb), .i_data_block_wb(wb_data),
    .o_stall(stall), .o_block_we(block_we), .o_fill_block(fill_block),
    .o_mem_req_valid(req_valid), .i_mem_req_ready(req_ready), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_resp_valid(resp_valid),
    .i_mem_rdata(rdata), .o_hit_count(hit_cnt), .o_miss_count(miss_cnt),
    .o_wb_count(wb_cnt)
  );

  dcache_ctrl #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .CNT_WIDTH(4)) dut4 (
    .i_clk(clk), .i_arst_n(arst_n), .i_mem_access(mem_access), .i_addr(addr),
    .i_hit(hit), .i_dirty(dirty), .i_addr_wb(addr_wb), .i_data_block_wb(wb_data),
    .o_stall(stall4), .o_block_we(block_we4), .o_fill_block(fill_block4),
    .o_mem_req_valid(req_valid4), .i_mem_req_ready(req_ready), .o_mem_we(mem_we4),
    .o_mem_addr(mem_addr4), .o_mem_wdata(mem_wdata4), .i_mem_resp_valid(resp_valid),
    .i_mem_rdata(rdata), .o_hit_count(hit_cnt4), .o_miss_count(miss_cnt4),
    .o_wb_count(wb_cnt4)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } req_t;

  req_t          exp_req[$];
  logic [BW-1:0] exp_fill[$];
  logic [BW-1:0] rd_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int force_rdy = -1;
  int force_rsp = -1;
  int unsigned m_hits = 0, m_miss = 0, m_wb = 0;

  function automatic void check(input string name, input logic [BW-1:0] act,
                                input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] b;
    for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic check_cnts(input string tag);
    check({tag, "_hits"}, hit_cnt, CW'(m_hits));
    check({tag, "_miss"}, miss_cnt, CW'(m_miss));
    check({tag, "_wb"},   wb_cnt,   CW'(m_wb));
  endtask

  // Memory model: random ready delay, random response delay, spurious
  // resp_valid whenever the controller should be ignoring it.
  initial begin
    int   phase, cnt, dly;
    bit   chosen;
    logic cur_we;
    phase = 0; cnt = 0; dly = 0; chosen = 0; cur_we = 0;
    req_ready = 0; resp_valid = 0; rdata = '0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        phase = 0; cnt = 0; chosen = 0; req_ready = 0; resp_valid = 0;
        continue;
      end
      if (phase == 0) begin
        req_ready  = 0;
        resp_valid = ($urandom_range(0, 3) == 0);
        rdata      = rand_blk();
        if (req_valid) begin
          if (!chosen) begin
            dly    = (force_rdy >= 0) ? force_rdy : $urandom_range(0, 3);
            chosen = 1;
          end
          if (cnt >= dly) begin
            req_ready  = 1;
            cur_we     = mem_we;
            resp_valid = $urandom_range(0, 1);
            dly        = (force_rsp >= 0) ? force_rsp : $urandom_range(0, 3);
            phase = 1; cnt = 0; chosen = 0;
          end else begin
            cnt++;
          end
        end
      end else begin
        req_ready = 0;
        if (cnt >= dly) begin
          resp_valid = 1;
          if (!cur_we && rd_q.size() > 0) rdata = rd_q.pop_front();
          else                            rdata = rand_blk();
          phase = 0; cnt = 0;
        end else begin
          resp_valid = 0;
          cnt++;
        end
      end
    end
  end

  // Monitor: pops expectations at each request handshake and allocate strobe.
  initial begin
    logic pend;
    req_t prev, e;
    pend = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!arst_n) begin
        pend = 0;
        continue;
      end
      if (pend) begin
        check("req_hold_valid", req_valid, 1'b1);
        check("req_hold_we", mem_we, prev.we);
        check("req_hold_addr", mem_addr, prev.addr);
        if (prev.we) check("req_hold_wdata", mem_wdata, prev.data);
      end
      if (req_valid && req_ready) begin
        pend = 0;
        if (exp_req.size() == 0) begin
          check("req_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_req.pop_front();
          check("req_we", mem_we, e.we);
          check("req_addr", mem_addr, e.addr);
          if (e.we) check("req_wdata", mem_wdata, e.data);
        end
      end else if (req_valid) begin
        pend = 1;
        prev = '{mem_we, mem_addr, mem_wdata};
      end else begin
        pend = 0;
      end
      if (block_we) begin
        if (exp_fill.size() == 0) check("alloc_unexpected", 1'b1, 1'b0);
        else                      check("fill_data", fill_block, exp_fill.pop_front());
      end
    end
  end

  task automatic do_idle();
    mem_access = 0;
    hit  = $urandom_range(0, 1);
    addr = {$urandom, $urandom};
    #1;
    check("idle_stall", stall, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_hit(input logic [AW-1:0] a);
    mem_access = 1;
    addr  = a;
    hit   = 1;
    dirty = $urandom_range(0, 1);
    #1;
    check("hit_stall", stall, 1'b0);
    check("hit_noreq", req_valid, 1'b0);
    m_hits++;
    @(negedge clk);
  endtask

  task automatic do_miss(input logic [AW-1:0] a, input logic d,
                         input logic [AW-1:0] wba, input logic [BW-1:0] wbd,
                         input bit wiggle, output int stalls, output int we_cycle);
    logic [BW-1:0] f;
    bit got_we;
    f = rand_blk();
    mem_access = 1; addr = a; hit = 0; dirty = d; addr_wb = wba; wb_data = wbd;
    if (d) begin
      exp_req.push_back('{1'b1, wba, wbd});
      m_wb++;
    end
    exp_req.push_back('{1'b0, a & ~64'h3F, '0});
    exp_fill.push_back(f);
    rd_q.push_back(f);
    m_miss++;
    stalls = 0; we_cycle = 0; got_we = 0;
    for (int c = 0; c < 200; c++) begin
      #1;
      check("miss_stall", stall, 1'b1);
      stalls++;
      if (c > 0) check_cnts("stalled");
      if (block_we) begin
        we_cycle = c + 1;
        got_we   = 1;
      end
      @(negedge clk);
      if (got_we) break;
      if (wiggle) mem_access = $urandom_range(0, 1);
    end
    check("miss_completed", got_we, 1'b1);
    mem_access = 1;
    hit = 1;
    #1;
    check("replay_stall", stall, 1'b0);
    m_hits++;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, wec, r;
    logic [AW-1:0] a;
    arst_n = 0; mem_access = 0; hit = 0; dirty = 0;
    addr = '0; addr_wb = '0; wb_data = '0;
    #2;
    check("rst_stall", stall, 1'b0);
    check("rst_block_we", block_we, 1'b0);
    check("rst_fill", fill_block, '0);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check_cnts("rst");
    @(negedge clk);
    @(negedge clk);
    arst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) do_hit({$urandom, $urandom});
    check_cnts("three_hits");
    for (int i = 0; i < 13; i++) do_hit({$urandom, $urandom});
    check("wrap_hits32", hit_cnt, CW'(16));
    check("wrap_hits4", hit_cnt4, 4'd0);

    force_rdy = 0; force_rsp = 0;
    do_miss(64'h0000_0000_0000_1234, 1'b0, '0, '0, 0, stalls, wec);
    check("clean_stall_cycles", stalls, 4);
    check("clean_alloc_cycle", wec, 4);
    check_cnts("clean");

    force_rdy = -1; force_rsp = -1;
    do_miss({$urandom, $urandom}, 1'b1, 64'h8000_0040, {64{8'hA5}}, 0, stalls, wec);
    check_cnts("dirty");

    force_rdy = 10; force_rsp = 0;
    do_miss({$urandom, $urandom}, 1'b0, '0, '0, 0, stalls, wec);
    check("bp_stall_cycles", stalls, 14);
    check_cnts("bp");
    force_rdy = -1; force_rsp = -1;

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      a = {$urandom, $urandom};
      if (r < 3)      do_idle();
      else if (r < 7) do_hit(a);
      else            do_miss(a, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                              rand_blk(), 1, stalls, wec);
    end
    check_cnts("random");
    check("final_hits4", hit_cnt4, 4'(m_hits));
    check("final_miss4", miss_cnt4, 4'(m_miss));
    check("final_wb4", wb_cnt4, 4'(m_wb));

    // Abort a miss while it waits for fill data.
    force_rdy = 0; force_rsp = 40;
    mem_access = 1; addr = {$urandom, $urandom}; hit = 0; dirty = 0;
    exp_req.push_back('{1'b0, addr & ~64'h3F, '0});
    m_miss++;
    begin
      bit seen;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        #1;
        if (req_valid && req_ready) seen = 1;
        @(negedge clk);
      end
      check("rst_reached_fill_wait", seen, 1'b1);
    end
    #3;
    arst_n = 0;
    #1;
    check("abort_stall", stall, 1'b0);
    check("abort_req_valid", req_valid, 1'b0);
    check("abort_block_we", block_we, 1'b0);
    check("abort_hits", hit_cnt, '0);
    check("abort_miss", miss_cnt, '0);
    check("abort_wb", wb_cnt, '0);
    @(negedge clk);
    @(negedge clk);
    mem_access = 0;
    m_hits = 0; m_miss = 0; m_wb = 0;
    exp_req.delete(); exp_fill.delete(); rd_q.delete();
    force_rdy = -1; force_rsp = -1;
    arst_n = 1;
    for (int i = 0; i < 30; i++) begin
      #1;
      check("post_rst_no_alloc", block_we, 1'b0);
      do_idle();
    end
    check_cnts("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Miss-handling sequencer for the 4-way write-back data cache.
- Watches hit/dirty status from the cache arrays each access and stalls the pipeline on a miss.
- Writes back the PLRU victim block to memory when it is dirty, then fetches the missing block and pulses the cache's block write enable to allocate it.
- Sits between the memory-stage pipeline, the data cache arrays and the single-ported block memory interface. Also keeps hit/miss/write-back performance counters.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- BLOCK_WIDTH, 512, cache block width in bits; block offset bits = $clog2(BLOCK_WIDTH/8) = 6.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- i_clk  in  1  clock.
- i_arst_n  in  1  asynchronous active-low reset.
- i_mem_access  in  1  pipeline has a load or store in the memory stage this cycle.
- i_addr  in  ADDR_WIDTH  access address; the pipeline holds it stable while o_stall=1.
- i_hit  in  1  cache hit for i_addr.
- i_dirty  in  1  PLRU victim of i_addr's set is dirty.
- i_addr_wb  in  ADDR_WIDTH  victim write-back address from the cache.
- i_data_block_wb  in  BLOCK_WIDTH  victim block data from the cache.
- o_stall  out  1  freeze the pipeline.
- o_block_we  out  1  one-cycle allocate strobe to the cache.
- o_fill_block  out  BLOCK_WIDTH  fill data to the cache.
- o_mem_req_valid  out  1  block memory request valid.
- i_mem_req_ready  in  1  memory accepts the request.
- o_mem_we  out  1  1 = block write (write-back), 0 = block read (fill).
- o_mem_addr  out  ADDR_WIDTH  block-aligned request address.
- o_mem_wdata  out  BLOCK_WIDTH  write-back data.
- i_mem_resp_valid  in  1  request complete; read data valid when the request was a read.
- i_mem_rdata  in  BLOCK_WIDTH  fill data.
- o_hit_count, o_miss_count, o_wb_count  out  CNT_WIDTH each  performance counters.

Behaviour:
- Reset (async, i_arst_n=0):
  - State=IDLE; all counters, the fill buffer and the miss-address register clear to 0.
  - All outputs are 0; o_mem_addr and o_mem_wdata are 0.
- State IDLE:
  - o_stall = i_mem_access & ~i_hit, combinational, same cycle.
  - On a miss: latch i_addr into miss_addr and increment o_miss_count. Go to WB_REQ if i_dirty (also increment o_wb_count), else FILL_REQ.
  - On a hit (i_mem_access & i_hit): increment o_hit_count.
- WB_REQ:
  - Drive o_mem_req_valid=1, o_mem_we=1, o_mem_addr=i_addr_wb, o_mem_wdata=i_data_block_wb.
  - Hold all of these until i_mem_req_ready, then go to WB_WAIT.
  - Victim data stays valid because the cache is not written and the set's PLRU does not change while stalled.
- WB_WAIT: on i_mem_resp_valid, go to FILL_REQ.
- FILL_REQ:
  - Drive o_mem_req_valid=1, o_mem_we=0, o_mem_addr = miss_addr with the low 6 bits zeroed.
  - On i_mem_req_ready, go to FILL_WAIT.
- FILL_WAIT: on i_mem_resp_valid, capture i_mem_rdata into the fill buffer and go to ALLOC.
- ALLOC:
  - o_block_we=1 for exactly one cycle, o_fill_block = fill buffer; then go to IDLE.
  - The replayed access hits in the next cycle.
- Stall coverage: o_stall=1 in every state except IDLE, including ALLOC.
- Request/response rules:
  - o_mem_req_valid never drops before the handshake completes.
  - i_mem_resp_valid is ignored outside the WAIT states.
  - i_mem_req_ready and i_mem_resp_valid in the same cycle in a REQ state: the response is not accepted until the WAIT state.
- Counters wrap modulo 2^CNT_WIDTH. No counting in non-IDLE states.
- Minimum clean-miss latency, with ready and response each arriving after one cycle: IDLE→FILL_REQ→FILL_WAIT→ALLOC→IDLE, so 4 stall cycles.
- Reset asserted mid-sequence aborts immediately to IDLE. Any outstanding memory transaction is the memory's responsibility.
- i_mem_access dropping while not in IDLE is ignored; the miss completes.

Decomposition:
- Shared package dcache_pkg holds:
  - enum t_dcache_state {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, ALLOC};
  - BLOCK_OFFSET_WIDTH constant;
  - a block-align function.
- No sub-module. The three counters are instances of one small generic counter, dcache_perf_cnt (enable, wrap).

Test Plan:
- Hit: i_mem_access=1, i_hit=1 for 3 cycles → o_stall=0 throughout, o_hit_count=3, no memory request.
- Clean miss:
  - Stimulus: i_addr=0x0000_0000_0000_1234, i_hit=0, i_dirty=0; ready and response each after 1 cycle.
  - Response: o_mem_addr=0x1200, o_mem_we=0; o_block_we pulses in the 4th cycle with o_fill_block = returned data; o_miss_count=1.
- Dirty miss:
  - Stimulus: i_dirty=1, i_addr_wb=0x8000_0040, victim pattern 0xA5 repeated.
  - Response: a write request with that address and data comes first, then a read request at the block-aligned miss address; o_wb_count=1; o_block_we pulses exactly once.
- Backpressure: i_mem_req_ready held 0 for 10 cycles in FILL_REQ → o_mem_req_valid and o_mem_addr stay stable, o_stall=1, counters unchanged.
- Reset in FILL_WAIT: drive i_arst_n low asynchronously → state IDLE, o_stall=0, o_mem_req_valid=0, counters 0, no o_block_we afterwards.
- Wrap: preload CNT_WIDTH=4 build, 16 hits → o_hit_count=0.
